jk_cmd_sequencer: RTL

//  Upstream driver for one jk_flipflop. Queues set/clear/toggle/hold commands via valid/ready.

---
 rtl/jk_pkg.sv | 12 +
 rtl/jk_cmd_fifo.sv | 50 +++++
 rtl/jk_flipflop.sv | 18 +
 rtl/jk_cmd_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for the JK command sequencer: JK drive codes and FSM states.
package jk_pkg;
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;
endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; wrapping pointers plus an occupancy count.
import jk_pkg::*;

module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/jk_flipflop.sv
// JK flop with a qin hold path; 00 reloads qin, so the upstream keeps it in step.
import jk_pkg::*;

module jk_flipflop (
    input  logic       clk,
    input  logic [1:0] jk,
    input  logic       qin,
    output logic       qout
);
    always_ff @(posedge clk) begin
        case (jk)
            JK_HOLD: qout <= qin;
            JK_CLR:  qout <= 1'b0;
            JK_SET:  qout <= 1'b1;
            default: qout <= ~qout;
        endcase
    end
endmodule

// File: rtl/jk_cmd_sequencer.sv
// Replays queued JK commands rpt+1 cycles each and cross-checks the flop
// against a shadow model of its Q.
import jk_pkg::*;

module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int REPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    input  logic [1:0]      cmd_op,
    input  logic [REPW-1:0] cmd_rpt,
    output logic            cmd_ready,
    output logic [1:0]      jk,
    output logic            qin,
    input  logic            q_fb,
    input  logic            clr_mismatch,
    output logic            busy,
    output logic            exp_q,
    output logic            exp_valid,
    output logic            mismatch
);
    localparam int W  = 2 + REPW;
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_e      state, state_n;
    logic [REPW-1:0] cnt, cnt_n;
    logic [1:0]      jk_n;
    logic            pop, full, empty;
    logic [W-1:0]    rdata;
    logic [CW-1:0]   count;

    jk_cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata ({cmd_op, cmd_rpt}),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Ready depends only on the registered count, never on this cycle's pop.
    assign cmd_ready = !full;
    assign busy      = (count != '0) || (state == ISSUE);
    assign qin       = exp_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        jk_n    = jk;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                jk_n = JK_HOLD;
                if (!empty) begin
                    pop     = 1'b1;
                    jk_n    = rdata[W-1 -: 2];
                    cnt_n   = rdata[REPW-1:0];
                    state_n = ISSUE;
                end
            end
            default: begin
                if (cnt != '0) begin
                    cnt_n = cnt - REPW'(1);
                end else if (!empty) begin
                    pop   = 1'b1;
                    jk_n  = rdata[W-1 -: 2];
                    cnt_n = rdata[REPW-1:0];
                end else begin
                    jk_n    = JK_HOLD;
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            jk    <= JK_HOLD;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            jk    <= jk_n;
        end
    end

    // Shadow Q follows what the flop samples this edge; toggle from an
    // unknown state stays unknown, so only 00/01/10 make it determinate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            case (jk)
                JK_HOLD: exp_q <= qin;
                JK_CLR:  exp_q <= 1'b0;
                JK_SET:  exp_q <= 1'b1;
                default: exp_q <= ~exp_q;
            endcase
            exp_valid <= exp_valid || (jk != JK_TGL);
            if (exp_valid && (q_fb != exp_q)) mismatch <= 1'b1;
            else if (clr_mismatch)            mismatch <= 1'b0;
        end
    end
endmodule
